// File: rtl/rr_arbiter_param_if.sv
// Bundle of request/grant signals for the round-robin arbiter.
// Handshake: a requester holds req_i high until it sees its grant bit; the
// holder signals completion with a single-cycle release_i pulse, and only
// that pulse (or a forced timeout) ends the grant.
interface rr_arbiter_param_if #(
  parameter int N_REQ = 4
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_i;
  logic             release_i;
  logic [N_REQ-1:0] grant_o;
  logic             grant_valid_o;
  logic [IDX_W-1:0] grant_idx_o;
  logic [N_REQ-1:0] priority_order_o;
  logic             timeout_o;
  logic             state_o;  // debug view of the FSM: 0 = IDLE, 1 = BUSY

  // Side that drives requests and observes grants.
  modport master (
    output req_i, release_i,
    input  grant_o, grant_valid_o, grant_idx_o, priority_order_o, timeout_o, state_o
  );

  // Arbiter side.
  modport slave (
    input  req_i, release_i,
    output grant_o, grant_valid_o, grant_idx_o, priority_order_o, timeout_o, state_o
  );
endinterface

// File: rtl/rr_arbiter_param.sv
// Round-robin arbiter with a rotating one-hot priority pointer.
// A grant is held until release_i; the pointer moves to just past the
// winner when a grant issues. Optional hold timeout: define
// RR_ARB_TIMEOUT_EN to force a release after MAX_HOLD BUSY cycles.
module rr_arbiter_param #(
  parameter int N_REQ     = 4,
  parameter int RESET_IDX = 2,
  parameter int MAX_HOLD  = 16
) (
  input logic                clk,
  input logic                reset,
  rr_arbiter_param_if.slave  bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] PRIO_RST = {{(N_REQ-1){1'b0}}, 1'b1} << RESET_IDX;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] prio_q, prio_d;
  logic [IDX_W-1:0] ptr_idx;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] nxt_idx;
  logic             found;
  logic             timeout_hit;
  logic [IDX_W-1:0] grant_idx;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // Forced release fires on the MAX_HOLD-th BUSY cycle unless a real release wins.
  assign timeout_hit = (state_q == BUSY) && (hold_cnt_q == CNT_W'(MAX_HOLD)) && !bus.release_i;

  // Hold counter: 1 on the first BUSY cycle, counts up while BUSY, 0 otherwise.
  always_comb begin
    hold_cnt_d = '0;
    if (state_d == BUSY) begin
      hold_cnt_d = (state_q == BUSY) ? hold_cnt_q + 1'b1 : CNT_W'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (reset) hold_cnt_q <= '0;
    else       hold_cnt_q <= hold_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Rotating search starting at the pointer; first asserted request wins.
  always_comb begin
    ptr_idx = '0;
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (prio_q[i]) ptr_idx = IDX_W'(i);
    end
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_idx} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!found && bus.req_i[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
    nxt_idx = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  // Next-state logic: grant from IDLE, hold in BUSY until release or timeout.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          prio_d           = '0;
          prio_d[nxt_idx]  = 1'b1;
          state_d          = BUSY;
        end
      end
      BUSY: begin
        if (bus.release_i || timeout_hit) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      prio_q  <= PRIO_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  // Binary index of the registered grant; 0 when nothing is granted.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) grant_idx = IDX_W'(i);
    end
  end

  assign bus.grant_o          = grant_q;
  assign bus.grant_valid_o    = |grant_q;
  assign bus.grant_idx_o      = grant_idx;
  assign bus.priority_order_o = prio_q;
  assign bus.timeout_o        = timeout_hit;
  assign bus.state_o          = (state_q == BUSY);
endmodule

// File: tb/tb_rr_arbiter_param.sv
// Directed bench for rr_arbiter_param (N_REQ=4, RESET_IDX=2, default build).
module tb_rr_arbiter_param;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  rr_arbiter_param_if #(.N_REQ(4)) bus ();

  rr_arbiter_param #(.N_REQ(4), .RESET_IDX(2), .MAX_HOLD(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] p,
                         input logic busy);
    logic [1:0] gi;
    gi = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) gi = 2'(i);
    chk({tag, ".grant"}, 32'(bus.grant_o), 32'(g));
    chk({tag, ".prio"},  32'(bus.priority_order_o), 32'(p));
    chk({tag, ".valid"}, 32'(bus.grant_valid_o), 32'(g != 4'b0));
    chk({tag, ".idx"},   32'(bus.grant_idx_o), 32'(gi));
    chk({tag, ".tmo"},   32'(bus.timeout_o), 32'(1'b0));
    chk({tag, ".state"}, 32'(bus.state_o), 32'(busy));
  endtask

  logic [3:0] exp_grant [5];
  logic [3:0] exp_prio  [5];

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_grant   = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    exp_prio    = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    // Reset
    reset         = 1'b1;
    bus.req_i     = 4'b0000;
    bus.release_i = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk_all("reset", 4'b0000, 4'b0100, 1'b0);

    // release_i in IDLE with no requests changes nothing
    bus.release_i = 1'b1;
    step();
    bus.release_i = 1'b0;
    chk_all("idle_rel", 4'b0000, 4'b0100, 1'b0);
    step();
    chk_all("idle_rel2", 4'b0000, 4'b0100, 1'b0);

    // All requesting: rotation 2,3,0,1,2, each held 2 cycles then released
    bus.req_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      chk_all($sformatf("rr%0d_g", n), exp_grant[n], exp_prio[n], 1'b1);
      step();
      chk_all($sformatf("rr%0d_h", n), exp_grant[n], exp_prio[n], 1'b1);
      bus.release_i = 1'b1;
      step();
      bus.release_i = 1'b0;
      chk_all($sformatf("rr%0d_r", n), 4'b0000, exp_prio[n], 1'b0);
    end
    bus.req_i = 4'b0000;
    step();
    chk_all("rr_idle", 4'b0000, 4'b1000, 1'b0);

    // Grant index 3, then drop the request without releasing for 5 cycles
    bus.req_i = 4'b1000;
    step();
    chk_all("hold_g", 4'b1000, 4'b0001, 1'b1);
    bus.req_i = 4'b0000;
    for (int n = 0; n < 5; n++) begin
      step();
      chk_all($sformatf("hold%0d", n), 4'b1000, 4'b0001, 1'b1);
    end
    bus.release_i = 1'b1;
    step();
    bus.release_i = 1'b0;
    chk_all("hold_rel", 4'b0000, 4'b0001, 1'b0);

    // Pointer at 0: requests 3 and 1 -> search 0,1 -> winner 1
    bus.req_i = 4'b1010;
    step();
    chk_all("skip_g", 4'b0010, 4'b0100, 1'b1);
    // Request changes while BUSY are ignored
    bus.req_i = 4'b0101;
    step();
    chk_all("busy_ign", 4'b0010, 4'b0100, 1'b1);
    bus.release_i = 1'b1;
    step();
    bus.release_i = 1'b0;
    chk_all("skip_rel", 4'b0000, 4'b0100, 1'b0);
    // Pointer at 2, requests 0 and 2 -> winner 2
    step();
    chk_all("ptr2_g", 4'b0100, 4'b1000, 1'b1);
    bus.req_i     = 4'b0000;
    bus.release_i = 1'b1;
    step();
    bus.release_i = 1'b0;
    chk_all("ptr2_rel", 4'b0000, 4'b1000, 1'b0);

    // Reset, then a single request from requester 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all("rst2", 4'b0000, 4'b0100, 1'b0);
    bus.req_i = 4'b0001;
    step();
    chk_all("single_g", 4'b0001, 4'b0010, 1'b1);

    // Move to grant 0010, then reset in the middle of BUSY with a request pending
    bus.release_i = 1'b1;
    step();
    bus.release_i = 1'b0;
    bus.req_i     = 4'b0010;
    step();
    chk_all("pre_rst_g", 4'b0010, 4'b0100, 1'b1);
    reset         = 1'b1;
    bus.release_i = 1'b1;
    step();
    chk_all("busy_rst", 4'b0000, 4'b0100, 1'b0);
    reset         = 1'b0;
    bus.release_i = 1'b0;
    bus.req_i     = 4'b0000;
    step();
    chk_all("post_rst", 4'b0000, 4'b0100, 1'b0);

    // Long hold: no timeout in the default build, grant persists past 16 cycles
    bus.req_i = 4'b0001;
    step();
    chk_all("long_g", 4'b0001, 4'b0010, 1'b1);
    bus.req_i = 4'b0000;
    for (int n = 0; n < 20; n++) step();
    chk_all("long_h", 4'b0001, 4'b0010, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
